cmd_sequencer: RTL and testbench

- Parametrised, synthesizable command player that drives the RemoteComm command interface (cmd/snd_cmd/cmd_snt/resp_rdy/resp) of the KnightsTour design.
- Holds a buffer of up to NUM_CMDS 16-bit commands (calibrate, move, tour), issues them in order and waits, with timeouts, for transmit-complete and acknowledge.
- Checks each response against the positive-ack code and logs errors.
- Used for on-board self-test and as a reusable stimulus engine for multi-move benches.

---
 rtl/cmd_seq_pkg.sv | 32 +++
 rtl/cmd_seq_if.sv | 17 +
 rtl/cmd_seq_buf.sv | 46 ++++
 rtl/cmd_sequencer.sv | 176 +++++++++++++++++
 tb/tb_cmd_sequencer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_seq_pkg.sv
// Shared types and constants for the RemoteComm command sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmd_seq_pkg;

  localparam int RESP_W = 8;
  localparam logic [RESP_W-1:0] POS_ACK = 8'hA5;

  // KnightsTour command encodings
  localparam logic [15:0] CMD_CAL    = 16'h0000;
  localparam logic [15:0] CMD_MOVE_N = 16'h2001;
  localparam logic [15:0] CMD_MOVE_E = 16'h2BF1;
  localparam logic [15:0] CMD_MOVE_W = 16'h23F1;
  localparam logic [15:0] CMD_MOVE_S = 16'h27F1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_SNT,
    ST_WAIT_RESP,
    ST_NEXT,
    ST_FIN
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_SNT_TMO  = 2'b01,
    ERR_RESP_TMO = 2'b10,
    ERR_NACK     = 2'b11
  } err_code_t;

endpackage

// File: rtl/cmd_seq_if.sv
// RemoteComm command channel: command word + send strobe out, transmit-complete
// and response byte back. Latency: n/a. Backpressure: the sender waits on cmd_snt.
// Ports: master = sequencer side (drives cmd/snd_cmd), slave = RemoteComm side.
interface cmd_seq_if
  import cmd_seq_pkg::*;
#(
  parameter int CMD_W = 16
);
  logic [CMD_W-1:0]  cmd;
  logic              snd_cmd;
  logic              cmd_snt;
  logic              resp_rdy;
  logic [RESP_W-1:0] resp;

  modport master (output cmd, snd_cmd, input cmd_snt, resp_rdy, resp);
  modport slave  (input cmd, snd_cmd, output cmd_snt, resp_rdy, resp);
endinterface

// File: rtl/cmd_seq_buf.sv
// Command buffer: NUM_CMDS x CMD_W registers appended at count, read by index.
// Latency: write visible next cycle; read is combinational.
// Backpressure: writes while full are dropped; clr beats wr_en in the same cycle.
// Ports: wr_en/wr_cmd append, clr empties, rd_idx/rd_cmd read, count/full status.
module cmd_seq_buf #(
  parameter int NUM_CMDS = 8,
  parameter int CMD_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [CMD_W-1:0]              wr_cmd,
  input  logic                          clr,
  input  logic [$clog2(NUM_CMDS)-1:0]   rd_idx,
  output logic [CMD_W-1:0]              rd_cmd,
  output logic [$clog2(NUM_CMDS+1)-1:0] count,
  output logic                          full
);
  localparam int IW = $clog2(NUM_CMDS);
  localparam int CW = $clog2(NUM_CMDS+1);

  logic [CMD_W-1:0] mem [NUM_CMDS];
  logic             do_wr;

  assign full   = (count == CW'(NUM_CMDS));
  assign do_wr  = wr_en && !clr && !full;
  assign rd_cmd = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (do_wr) begin
      count <= count + CW'(1);
    end
  end

  // Storage carries no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[IW'(count)] <= wr_cmd;
    end
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Command player for RemoteComm: replays the buffered commands in order, checks
// each ack, logs the first error. Latency: start->snd_cmd 2 cycles, last resp->done 2.
// Backpressure: one command in flight; waits cmd_snt then resp, each with a timeout.
// Ports: clk/rst_n; wr_en/wr_cmd/clr/start control; rc (cmd_seq_if.master) RemoteComm
// side; busy/done/err/err_code/err_idx/err_cnt/count/full status.
// Build option: SEQ_ABORT_ON_ERR_EN ends playback at the first logged error.
module cmd_sequencer
  import cmd_seq_pkg::*;
#(
  parameter int                NUM_CMDS = 8,
  parameter int                CMD_W    = 16,
  parameter int                TMO_W    = 24,
  parameter int                SNT_TMO  = 200000,
  parameter int                RESP_TMO = 4000000,
  parameter logic [RESP_W-1:0] ACK_VAL  = POS_ACK
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [CMD_W-1:0]              wr_cmd,
  input  logic                          clr,
  input  logic                          start,
  cmd_seq_if.master                     rc,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [1:0]                    err_code,
  output logic [$clog2(NUM_CMDS)-1:0]   err_idx,
  output logic [$clog2(NUM_CMDS+1)-1:0] err_cnt,
  output logic [$clog2(NUM_CMDS+1)-1:0] count,
  output logic                          full
);
  localparam int IW = $clog2(NUM_CMDS);
  localparam int CW = $clog2(NUM_CMDS+1);

`ifdef SEQ_ABORT_ON_ERR_EN
  localparam seq_state_t ERR_DEST = ST_FIN;
`else
  localparam seq_state_t ERR_DEST = ST_NEXT;
`endif

  seq_state_t       state, state_nxt;
  logic [IW-1:0]    idx;
  logic [TMO_W-1:0] tmo_cnt;
  logic [CMD_W-1:0] rd_cmd, cmd_q;
  logic             snd_q;
  err_code_t        err_code_q;
  logic             start_acc, ld_cmd, tmo_clr, tmo_inc, idx_inc, log_err;
  err_code_t        log_code;

  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_FIN);
  assign rc.cmd      = cmd_q;
  assign rc.snd_cmd  = snd_q;
  assign err_code    = err_code_q;

  // Buffer edits are frozen while a playback is running.
  cmd_seq_buf #(.NUM_CMDS(NUM_CMDS), .CMD_W(CMD_W)) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en && !busy),
    .wr_cmd (wr_cmd),
    .clr    (clr && !busy),
    .rd_idx (idx),
    .rd_cmd (rd_cmd),
    .count  (count),
    .full   (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    ld_cmd    = 1'b0;
    tmo_clr   = 1'b0;
    tmo_inc   = 1'b0;
    idx_inc   = 1'b0;
    log_err   = 1'b0;
    log_code  = ERR_NONE;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = (count == '0) ? ST_FIN : ST_SEND;
        end
      end
      ST_SEND: begin
        ld_cmd    = 1'b1;
        tmo_clr   = 1'b1;
        state_nxt = ST_WAIT_SNT;
      end
      ST_WAIT_SNT: begin
        if (rc.cmd_snt) begin
          tmo_clr   = 1'b1;
          state_nxt = ST_WAIT_RESP;
        end else if (tmo_cnt == TMO_W'(SNT_TMO - 1)) begin
          log_err   = 1'b1;
          log_code  = ERR_SNT_TMO;
          state_nxt = ERR_DEST;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      ST_WAIT_RESP: begin
        // A response arriving on the final timeout cycle still counts.
        if (rc.resp_rdy) begin
          if (rc.resp == ACK_VAL) begin
            state_nxt = ST_NEXT;
          end else begin
            log_err   = 1'b1;
            log_code  = ERR_NACK;
            state_nxt = ERR_DEST;
          end
        end else if (tmo_cnt == TMO_W'(RESP_TMO - 1)) begin
          log_err   = 1'b1;
          log_code  = ERR_RESP_TMO;
          state_nxt = ERR_DEST;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      ST_NEXT: begin
        idx_inc   = 1'b1;
        state_nxt = (CW'(idx) == count - CW'(1)) ? ST_FIN : ST_SEND;
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // snd_cmd is registered so it can never glitch, and cmd holds between sends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q      <= '0;
      snd_q      <= 1'b0;
      idx        <= '0;
      tmo_cnt    <= '0;
      err        <= 1'b0;
      err_code_q <= ERR_NONE;
      err_idx    <= '0;
      err_cnt    <= '0;
    end else begin
      snd_q <= ld_cmd;
      if (ld_cmd) cmd_q <= rd_cmd;

      if (start_acc)    idx <= '0;
      else if (idx_inc) idx <= idx + IW'(1);

      if (tmo_clr)      tmo_cnt <= '0;
      else if (tmo_inc) tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (start_acc) begin
        err        <= 1'b0;
        err_code_q <= ERR_NONE;
        err_idx    <= '0;
        err_cnt    <= '0;
      end else if (log_err) begin
        err <= 1'b1;
        if (!err) begin
          err_code_q <= log_code;
          err_idx    <= idx;
        end
        if (err_cnt != CW'(NUM_CMDS)) err_cnt <= err_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer with a scripted RemoteComm responder.
// Latency: n/a. Backpressure: responder delays are set per command.
// Ports: none (top-level bench).
module tb_cmd_sequencer;
  import cmd_seq_pkg::*;

  localparam int N      = 8;
  localparam int SNT_T  = 50;
  localparam int RESP_T = 100;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        wr_en  = 1'b0;
  logic        clr    = 1'b0;
  logic        start  = 1'b0;
  logic [15:0] wr_cmd = '0;
  logic        busy, done, err, full;
  logic [1:0]  err_code;
  logic [2:0]  err_idx;
  logic [3:0]  err_cnt, count;

  int n_vec    = 0;
  int n_mis    = 0;
  int done_cnt = 0;
  int exp_cnt  = 0;
  logic [15:0] snd_log[$];
  logic [15:0] exp_log[$];

  cmd_seq_if #(.CMD_W(16)) rc();

  always #5 clk = ~clk;

  cmd_sequencer #(
    .NUM_CMDS (N),
    .CMD_W    (16),
    .TMO_W    (8),
    .SNT_TMO  (SNT_T),
    .RESP_TMO (RESP_T),
    .ACK_VAL  (POS_ACK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_cmd   (wr_cmd),
    .clr      (clr),
    .start    (start),
    .rc       (rc),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .err_idx  (err_idx),
    .err_cnt  (err_cnt),
    .count    (count),
    .full     (full)
  );

  // Record every strobed command and every done pulse.
  always @(negedge clk) begin
    if (rc.snd_cmd === 1'b1) snd_log.push_back(rc.cmd);
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] c);
    wr_en = 1'b1; wr_cmd = c;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic go();
    snd_log.delete();
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for a strobe, then answer. Negative delay = never answer that phase.
  task automatic respond(input int snt_dly, input int resp_dly, input logic [7:0] rb);
    int t = 0;
    while (rc.snd_cmd !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    check("snd_strobe", rc.snd_cmd, 1);
    @(negedge clk);
    if (snt_dly < 0) return;
    repeat (snt_dly) @(negedge clk);
    rc.cmd_snt = 1'b1;
    @(negedge clk);
    rc.cmd_snt = 1'b0;
    if (resp_dly < 0) return;
    repeat (resp_dly) @(negedge clk);
    rc.resp = rb; rc.resp_rdy = 1'b1;
    @(negedge clk);
    rc.resp_rdy = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (done !== 1'b1 && done_cnt == 0 && t < 1000) begin @(negedge clk); t++; end
    check(tag, (done === 1'b1) || (done_cnt != 0), 1);
    repeat (3) @(negedge clk);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_pulses"}, done_cnt, 1);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, snd_log.size(), exp_log.size());
    foreach (exp_log[i]) begin
      if (i < snd_log.size()) check(tag, snd_log[i], exp_log[i]);
    end
  endtask

  initial begin
    rc.cmd_snt = 1'b0; rc.resp_rdy = 1'b0; rc.resp = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cmd", rc.cmd, 0);
    check("rst_snd", rc.snd_cmd, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", {err, err_code, err_idx, err_cnt}, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean three-command playback with exact latencies
    wr(CMD_CAL); wr(CMD_MOVE_E); wr(CMD_MOVE_N);
    check("load3_count", count, 3);
    go();
    check("start_busy", busy, 1);
    check("start_snd_c1", rc.snd_cmd, 0);
    @(negedge clk);
    check("start_snd_c2", rc.snd_cmd, 1);
    check("first_cmd", rc.cmd, CMD_CAL);
    respond(10, 20, POS_ACK);
    respond(10, 20, POS_ACK);
    respond(10, 20, POS_ACK);
    check("done_lat_c1", done, 0);
    @(negedge clk);
    check("done_lat_c2", done, 1);
    wait_done("s1_done");
    check("s1_err", err, 0);
    check("s1_err_cnt", err_cnt, 0);
    check("s1_cmd_hold", rc.cmd, CMD_MOVE_N);
    exp_log = {CMD_CAL, CMD_MOVE_E, CMD_MOVE_N};
    check_log("s1_log");

    // cmd_snt timeout on entry 1
    do_clr(); wr(CMD_CAL); wr(CMD_MOVE_N); wr(CMD_MOVE_S);
    go();
    respond(5, 5, POS_ACK);
    respond(-1, 0, POS_ACK);
`ifndef SEQ_ABORT_ON_ERR_EN
    respond(5, 5, POS_ACK);
    exp_log = {CMD_CAL, CMD_MOVE_N, CMD_MOVE_S};
`else
    exp_log = {CMD_CAL, CMD_MOVE_N};
`endif
    wait_done("s2_done");
    check("s2_err", err, 1);
    check("s2_code", err_code, 2'b01);
    check("s2_idx", err_idx, 1);
    check("s2_cnt", err_cnt, 1);
    check_log("s2_log");

    // NACK on entry 0, then response timeout on entry 1
    do_clr(); wr(CMD_MOVE_E); wr(CMD_MOVE_W);
    go();
    respond(3, 3, 8'h5A);
`ifndef SEQ_ABORT_ON_ERR_EN
    respond(3, -1, POS_ACK);
    exp_log = {CMD_MOVE_E, CMD_MOVE_W};
    exp_cnt = 2;
`else
    exp_log = {CMD_MOVE_E};
    exp_cnt = 1;
`endif
    wait_done("s3_done");
    check("s3_code", err_code, 2'b11);
    check("s3_idx", err_idx, 0);
    check("s3_cnt", err_cnt, exp_cnt);
    check_log("s3_log");

    // Overfill, replay all entries, clr beats wr_en, empty start
    do_clr();
    for (int i = 0; i < N + 2; i++) wr(16'h1000 + 16'(i));
    check("fill_count", count, N);
    check("fill_full", full, 1);
    go();
    for (int i = 0; i < N; i++) respond(1, 1, POS_ACK);
    wait_done("s4_done");
    exp_log.delete();
    for (int i = 0; i < N; i++) exp_log.push_back(16'h1000 + 16'(i));
    check_log("s4_log");
    check("s4_err", err, 0);
    clr = 1'b1; wr_en = 1'b1; wr_cmd = 16'hBEEF;
    @(negedge clk);
    clr = 1'b0; wr_en = 1'b0;
    check("clr_wins_count", count, 0);
    check("clr_wins_full", full, 0);
    go();
    check("empty_done_c1", done, 1);
    check("empty_snd", rc.snd_cmd, 0);
    repeat (3) @(negedge clk);
    check("empty_no_send", snd_log.size(), 0);
    check("empty_pulses", done_cnt, 1);
    check("empty_idle", busy, 0);

    // Start/write/clr while busy ignored; resp on final timeout cycle wins
    wr(CMD_MOVE_N);
    snd_log.delete(); done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    check("s5_busy", busy, 1);
    wr_en = 1'b1; wr_cmd = 16'hFFFF; clr = 1'b1;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0; clr = 1'b0;
    check("busy_edit_ignored", count, 1);
    respond(2, RESP_T - 1, POS_ACK);
    wait_done("s5_done");
    check("edge_resp_err", err, 0);
    exp_log = {CMD_MOVE_N};
    check_log("s5_log");

    // One cycle later the timeout has already fired
    go();
    respond(2, RESP_T, POS_ACK);
    wait_done("s5b_done");
    check("late_resp_err", err, 1);
    check("late_resp_code", err_code, 2'b10);
    check("late_resp_cnt", err_cnt, 1);
    check_log("s5b_log");

    // Asynchronous reset while waiting for a response
    go();
    respond(2, -1, POS_ACK);
    repeat (10) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_snd", rc.snd_cmd, 0);
    check("arst_err", err, 0);
    check("arst_count", count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    go();
    check("post_rst_empty_done", done, 1);
    repeat (3) @(negedge clk);
    check("post_rst_no_send", snd_log.size(), 0);
    wr(CMD_MOVE_S);
    go();
    respond(2, 2, POS_ACK);
    wait_done("s6_done");
    exp_log = {CMD_MOVE_S};
    check_log("s6_log");
    check("s6_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
